seven_segment_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode/cathode seven-segment display. It shares a single `Seven_Segment_Display_Hex` decoder across all digits by cycling the digit enables. It inserts blanking dead time between digits to suppress ghosting. Displayed data is updated only at frame boundaries, so the display never tears. It sits between the register/UI logic that supplies hex digits and the board-level segment and anode pins.

---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/seven_segment_scan_ctrl_hex.sv | 33 +++
 rtl/seven_segment_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seven_segment_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types, constants and polarity helper for the seven-segment scan controller.
// Pure declarations; no timing or flow control.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF_HIGH = 7'h00;
    localparam logic [6:0] SEG_ALL      = 7'h7F;

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seven_segment_scan_ctrl_hex.sv
// Hex nibble to active-high a..g segment decoder (bit 6 = a).
// Combinational, zero latency, no flow control.
module Seven_Segment_Display_Hex
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF_HIGH;
        case (hex)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = SEG_ALL;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            4'hF: seg = 7'h47;
            default: seg = SEG_OFF_HIGH;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner with dead time and frame-aligned updates.
// Pins are registered one cycle behind the scan state; load is always accepted (no backpressure).
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         R_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         B_LAST   = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    scan_state_t             state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;

    logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
    logic [NUM_DIGITS-1:0]   disp_blank, pend_blank;
    logic                    pend_valid;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              dec_seg;
    logic                    commit;

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = disp_data[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_blank = disp_blank[k];
            end
        end
    end

    Seven_Segment_Display_Hex u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

    // Frame boundary: last cycle of the last digit's drive slot.
    assign commit = (state == DRIVE) && (cnt == R_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            an         <= AN_OFF;
            seg        <= seg_polarity(SEG_OFF_HIGH, SEG_ACTIVE_LOW);
            dp         <= SEG_ACTIVE_LOW;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (state == BLANK) && (cnt == '0) && (idx == '0);
            if (state == DRIVE) begin
                an  <= AN_OFF ^ (cur_blank ? '0 : (AN_ONE << idx));
                seg <= seg_polarity(dec_seg, SEG_ACTIVE_LOW);
                dp  <= cur_dp ^ SEG_ACTIVE_LOW;
            end else begin
                an  <= AN_OFF;
                seg <= seg_polarity(SEG_OFF_HIGH, SEG_ACTIVE_LOW);
                dp  <= SEG_ACTIVE_LOW;
            end

            case (state)
                BLANK: begin
                    if (cnt == B_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == R_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase

            // A load coinciding with the boundary bypasses the pending set.
            if (commit && load) begin
                disp_data  <= data_in;
                disp_dp    <= dp_in;
                disp_blank <= blank_in;
                pend_valid <= 1'b0;
            end else if (commit && pend_valid) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for the scan controller: 4 digits, 8-cycle drive, 2-cycle dead time, active-low pins.
module tb_seven_segment_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int B     = 2;
    localparam int SLOT  = R + B;
    localparam int FRAME = N * SLOT;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] data_in  = '0;
    logic [3:0]  dp_in    = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    always #5 clk = ~clk;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .BLANK_CYCLES   (B),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    // Active-low segment patterns, hand-derived from the a..g truth table.
    function automatic logic [6:0] hex_seg_n(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int rel, input logic [3:0] blk);
        logic [3:0] one;
        int s;
        one = 4'b0001;
        s   = rel / SLOT;
        if ((rel % SLOT) < B || blk[s]) return 4'hF;
        return ~(one << s);
    endfunction

    function automatic logic [6:0] exp_seg(input int rel, input logic [15:0] d);
        int s;
        s = rel / SLOT;
        if ((rel % SLOT) < B) return 7'h7F;
        return hex_seg_n(d[4*s +: 4]);
    endfunction

    function automatic logic exp_dp(input int rel, input logic [3:0] dpv);
        int s;
        s = rel / SLOT;
        if ((rel % SLOT) < B) return 1'b1;
        return ~dpv[s];
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] blk);
        load     = 1'b1;
        data_in  = d;
        dp_in    = dpv;
        blank_in = blk;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL rst_an got=%h exp=f", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp got=%b exp=1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
        rst_n = 1'b1;
        cyc   = -1;
        for (int c = 0; c <= 15; c++) begin
            run_to(c);
            checks++;
            if (an !== exp_an(c, 4'h0)) begin
                errors++; $display("FAIL boot_an cyc=%0d got=%h exp=%h", c, an, exp_an(c, 4'h0));
            end
        end
        // Asynchronous reset in the middle of digit 1's drive slot.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL midrst_an got=%h exp=f", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL midrst_dp got=%b exp=1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got=%b exp=0", frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        for (int c = 0; c <= 12; c++) begin
            run_to(c);
            checks++;
            if (an !== exp_an(c, 4'h0)) begin
                errors++; $display("FAIL reboot_an cyc=%0d got=%h exp=%h", c, an, exp_an(c, 4'h0));
            end
            checks++;
            if (seg !== exp_seg(c, 16'h0)) begin
                errors++; $display("FAIL reboot_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(c, 16'h0));
            end
        end
    endtask

    task automatic test_scan_order();
        int rel;
        do_load(16'h8421, 4'b0001, 4'b0000);
        for (int c = 14; c < 2*FRAME; c++) begin
            run_to(c);
            rel = c % FRAME;
            if (c < FRAME) begin
                checks++;
                if (seg !== exp_seg(rel, 16'h0)) begin
                    errors++; $display("FAIL scan_early_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h0));
                end
            end else begin
                checks++;
                if (an !== exp_an(rel, 4'h0)) begin
                    errors++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", c, an, exp_an(rel, 4'h0));
                end
                checks++;
                if (seg !== exp_seg(rel, 16'h8421)) begin
                    errors++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h8421));
                end
                checks++;
                if (dp !== exp_dp(rel, 4'b0001)) begin
                    errors++; $display("FAIL scan_dp cyc=%0d got=%b exp=%b", c, dp, exp_dp(rel, 4'b0001));
                end
                checks++;
                if (frame_tick !== (rel == 0)) begin
                    errors++; $display("FAIL scan_tick cyc=%0d got=%b exp=%b", c, frame_tick, rel == 0);
                end
                checks++;
                if ($countones(~an) > 1) begin
                    errors++; $display("FAIL ghost_overlap cyc=%0d got=%h exp=at_most_one_low", c, an);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        int rel;
        run_to(2*FRAME + 15);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        tick();
        do_load(16'h5555, 4'b0000, 4'b0000);
        for (int c = 2*FRAME + 18; c < 4*FRAME; c++) begin
            run_to(c);
            rel = c % FRAME;
            if (c < 3*FRAME) begin
                checks++;
                if (seg !== exp_seg(rel, 16'h8421)) begin
                    errors++; $display("FAIL tear_old_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h8421));
                end
                checks++;
                if (dp !== exp_dp(rel, 4'b0001)) begin
                    errors++; $display("FAIL tear_old_dp cyc=%0d got=%b exp=%b", c, dp, exp_dp(rel, 4'b0001));
                end
            end else begin
                checks++;
                if (seg !== exp_seg(rel, 16'h5555)) begin
                    errors++; $display("FAIL tear_new_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h5555));
                end
                checks++;
                if (dp !== 1'b1) begin
                    errors++; $display("FAIL tear_new_dp cyc=%0d got=%b exp=1", c, dp);
                end
            end
            checks++;
            if (frame_tick !== (rel == 0)) begin
                errors++; $display("FAIL tear_tick cyc=%0d got=%b exp=%b", c, frame_tick, rel == 0);
            end
        end
    endtask

    task automatic test_simultaneous();
        int rel;
        run_to(4*FRAME + 5);
        do_load(16'h9999, 4'b1111, 4'b0000);
        for (int c = 4*FRAME + 6; c <= 5*FRAME - 2; c++) begin
            run_to(c);
            rel = c % FRAME;
            checks++;
            if (seg !== exp_seg(rel, 16'h5555)) begin
                errors++; $display("FAIL sim_cur_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h5555));
            end
        end
        // Load sampled on the same edge as the frame-boundary commit.
        do_load(16'h1234, 4'b0000, 4'b0000);
        for (int c = 5*FRAME - 1; c < 7*FRAME; c++) begin
            run_to(c);
            rel = c % FRAME;
            if (c < 5*FRAME) begin
                checks++;
                if (seg !== exp_seg(rel, 16'h5555)) begin
                    errors++; $display("FAIL sim_last_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h5555));
                end
            end else begin
                checks++;
                if (seg !== exp_seg(rel, 16'h1234)) begin
                    errors++; $display("FAIL sim_new_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h1234));
                end
                checks++;
                if (dp !== 1'b1) begin
                    errors++; $display("FAIL sim_new_dp cyc=%0d got=%b exp=1", c, dp);
                end
            end
        end
    endtask

    task automatic test_blanking();
        int rel;
        run_to(7*FRAME);
        do_load(16'h1234, 4'b0000, 4'b0100);
        for (int c = 7*FRAME + 1; c < 9*FRAME; c++) begin
            run_to(c);
            rel = c % FRAME;
            if (c < 8*FRAME) begin
                checks++;
                if (an !== exp_an(rel, 4'b0000)) begin
                    errors++; $display("FAIL blank_pre_an cyc=%0d got=%h exp=%h", c, an, exp_an(rel, 4'b0000));
                end
            end else begin
                checks++;
                if (an !== exp_an(rel, 4'b0100)) begin
                    errors++; $display("FAIL blank_an cyc=%0d got=%h exp=%h", c, an, exp_an(rel, 4'b0100));
                end
                checks++;
                if (an[2] !== 1'b1) begin
                    errors++; $display("FAIL blank_an2 cyc=%0d got=%b exp=1", c, an[2]);
                end
                checks++;
                if (seg !== exp_seg(rel, 16'h1234)) begin
                    errors++; $display("FAIL blank_seg cyc=%0d got=%h exp=%h", c, seg, exp_seg(rel, 16'h1234));
                end
                checks++;
                if (frame_tick !== (rel == 0)) begin
                    errors++; $display("FAIL blank_tick cyc=%0d got=%b exp=%b", c, frame_tick, rel == 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_simultaneous();
        test_blanking();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
